// File: rtl/code_pulse_pkg.sv
// Shared definitions for the code pulse generator: state encoding, chip limit,
// counter widths and the small parameter-conditioning helpers.
package code_pulse_pkg;

    localparam int MAX_CHIPS_DEF = 32;
    localparam int CODE_W        = 32;
    localparam int CHIP_W        = 5;
    localparam int DUR_W         = 16;
    localparam int ELAP_W        = 22;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TX     = 2'd1,
        ST_LISTEN = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // A zero chip duration is treated as one clock per chip.
    function automatic logic [DUR_W-1:0] eff_duration(input logic [DUR_W-1:0] d);
        return (d == '0) ? DUR_W'(1) : d;
    endfunction

    // Chip count clamped to the number of code bits available.
    function automatic logic [DUR_W-1:0] eff_chips(input logic [DUR_W-1:0] n,
                                                   input int max_chips);
        logic [DUR_W-1:0] lim;
        lim = DUR_W'(max_chips);
        return (n > lim) ? lim : n;
    endfunction

endpackage

// File: rtl/chip_timer.sv
// Reloadable per-chip down-counter. Loaded with the chip duration at pulse
// start; raises o_tc on the last clock of each chip and reloads itself.
module chip_timer
    import code_pulse_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [DUR_W-1:0] i_dur,
    output logic             o_tc
);

    logic [DUR_W-1:0] r_dur;
    logic [DUR_W-1:0] r_cnt;

    assign o_tc = (r_cnt == DUR_W'(1));

    // Load at pulse start, then count down and reload on each chip boundary.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dur <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_dur <= i_dur;
            r_cnt <= i_dur;
        end else if (i_en) begin
            if (o_tc) r_cnt <= r_dur;
            else      r_cnt <= r_cnt - DUR_W'(1);
        end
    end

endmodule

// File: rtl/code_pulse_generator.sv
// BPSK code pulse generator: on a GEN request, transmits N' chips of D' clocks
// each (RF gate + phase bit), listens for the rest of the P-clock window, then
// reports SIGNAL_GEN_OVER until the sequencer drops GEN.
module code_pulse_generator
    import code_pulse_pkg::*;
#(
    parameter int MAX_CHIPS = MAX_CHIPS_DEF
) (
    input  logic              CLOCK_10M,
    input  logic              RESET_N,
    input  logic              GEN,
    input  logic [CODE_W-1:0] CODE,
    input  logic [DUR_W-1:0]  CODE_LEN,
    input  logic [DUR_W-1:0]  CODE_DURATION,
    input  logic [DUR_W-1:0]  PULSE_LEN,
    input  logic              RF_OUTPUT_EN,
    output logic              RF_GATE,
    output logic              PHASE_BIT,
    output logic [CHIP_W-1:0] CHIP_INDEX,
    output logic              GEN_BUSY,
    output logic              SIGNAL_GEN_OVER
);

    state_t              r_state;
    logic [CODE_W-1:0]   r_code;
    logic [CHIP_W-1:0]   r_last;
    logic [DUR_W-1:0]    r_p;
    logic [ELAP_W-1:0]   r_e;
    logic [CHIP_W-1:0]   r_k;
    logic                r_phase;
    logic                r_rf;
    logic                r_busy;
    logic                r_over;

    logic [DUR_W-1:0]    w_n_eff;
    logic [DUR_W-1:0]    w_d_eff;
    logic                w_start;
    logic                w_tc;
    logic                w_win_end;
    logic [CHIP_W-1:0]   w_next_k;

    assign w_n_eff   = eff_chips(CODE_LEN, MAX_CHIPS);
    assign w_d_eff   = eff_duration(CODE_DURATION);
    assign w_start   = (r_state == ST_IDLE) && GEN;
    assign w_next_k  = r_k + CHIP_W'(1);
    // The current cycle is the last one of the P-clock window (e is 0-based).
    assign w_win_end = ({{(ELAP_W-DUR_W){1'b0}}, r_p} <= (r_e + ELAP_W'(1)));

    chip_timer u_chip_timer (
        .i_clk   (CLOCK_10M),
        .i_rst_n (RESET_N),
        .i_load  (w_start),
        .i_en    (r_state == ST_TX),
        .i_dur   (w_d_eff),
        .o_tc    (w_tc)
    );

    assign RF_GATE         = r_rf;
    assign PHASE_BIT       = r_phase;
    assign CHIP_INDEX      = r_k;
    assign GEN_BUSY        = r_busy;
    assign SIGNAL_GEN_OVER = r_over;

    // Pulse sequencing FSM; outputs are registered for the state being entered.
    always_ff @(posedge CLOCK_10M or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= ST_IDLE;
            r_code  <= '0;
            r_last  <= '0;
            r_p     <= '0;
            r_e     <= '0;
            r_k     <= '0;
            r_phase <= 1'b0;
            r_rf    <= 1'b0;
            r_busy  <= 1'b0;
            r_over  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (GEN) begin
                        r_code <= CODE;
                        r_last <= CHIP_W'(w_n_eff - DUR_W'(1));
                        r_p    <= PULSE_LEN;
                        r_e    <= '0;
                        r_busy <= 1'b1;
                        if (w_n_eff != '0) begin
                            r_state <= ST_TX;
                            r_k     <= '0;
                            r_phase <= CODE[0];
                            r_rf    <= RF_OUTPUT_EN;
                        end else if (PULSE_LEN != '0) begin
                            r_state <= ST_LISTEN;
                        end else begin
                            r_state <= ST_DONE;
                            r_over  <= 1'b1;
                        end
                    end
                end
                ST_TX: begin
                    if (!GEN) begin
                        r_state <= ST_IDLE;
                        r_e     <= '0;
                        r_k     <= '0;
                        r_phase <= 1'b0;
                        r_rf    <= 1'b0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_e <= r_e + ELAP_W'(1);
                        if (w_tc && (r_k == r_last)) begin
                            r_k     <= '0;
                            r_phase <= 1'b0;
                            r_rf    <= 1'b0;
                            if (w_win_end) begin
                                r_state <= ST_DONE;
                                r_over  <= 1'b1;
                            end else begin
                                r_state <= ST_LISTEN;
                            end
                        end else if (w_tc) begin
                            r_k     <= w_next_k;
                            r_phase <= r_code[w_next_k];
                            r_rf    <= RF_OUTPUT_EN;
                        end else begin
                            r_rf    <= RF_OUTPUT_EN;
                        end
                    end
                end
                ST_LISTEN: begin
                    if (!GEN) begin
                        r_state <= ST_IDLE;
                        r_e     <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_e <= r_e + ELAP_W'(1);
                        if (w_win_end) begin
                            r_state <= ST_DONE;
                            r_over  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (!GEN) begin
                        r_state <= ST_IDLE;
                        r_e     <= '0;
                        r_over  <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_code_pulse_generator.sv
// Bench for code_pulse_generator: directed pulses push expected reports into a
// scoreboard queue; a monitor accumulates each pulse and checks it when OVER rises.
module tb_code_pulse_generator;

    logic        CLOCK_10M;
    logic        RESET_N;
    logic        GEN;
    logic [31:0] CODE;
    logic [15:0] CODE_LEN;
    logic [15:0] CODE_DURATION;
    logic [15:0] PULSE_LEN;
    logic        RF_OUTPUT_EN;
    logic        RF_GATE;
    logic        PHASE_BIT;
    logic [4:0]  CHIP_INDEX;
    logic        GEN_BUSY;
    logic        SIGNAL_GEN_OVER;

    code_pulse_generator #(.MAX_CHIPS(32)) dut (
        .CLOCK_10M       (CLOCK_10M),
        .RESET_N         (RESET_N),
        .GEN             (GEN),
        .CODE            (CODE),
        .CODE_LEN        (CODE_LEN),
        .CODE_DURATION   (CODE_DURATION),
        .PULSE_LEN       (PULSE_LEN),
        .RF_OUTPUT_EN    (RF_OUTPUT_EN),
        .RF_GATE         (RF_GATE),
        .PHASE_BIT       (PHASE_BIT),
        .CHIP_INDEX      (CHIP_INDEX),
        .GEN_BUSY        (GEN_BUSY),
        .SIGNAL_GEN_OVER (SIGNAL_GEN_OVER)
    );

    initial CLOCK_10M = 1'b0;
    always #5 CLOCK_10M = ~CLOCK_10M;

    typedef struct {
        string       name;
        int          lat;
        int          rf;
        logic [63:0] trace;
        int          isum;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   stray  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", nm, act, req);
        end
    endtask

    // Monitor: measures each pulse from the edge sampling GEN high to OVER.
    int          cyc = 0;
    int          t_gen = 0;
    int          t_fall = 0;
    int          rf_cnt = 0;
    int          isum = 0;
    logic [63:0] trace = '0;
    logic        gen_q = 1'b0;
    logic        over_q = 1'b0;

    initial begin
        exp_t e;
        forever begin
            @(posedge CLOCK_10M);
            cyc++;
            if (GEN && !gen_q) begin
                t_gen  = cyc;
                rf_cnt = 0;
                isum   = 0;
                trace  = '0;
            end
            if (!GEN && gen_q) t_fall = cyc;
            gen_q = GEN;
            #1;
            if (RESET_N && !GEN_BUSY &&
                (RF_GATE || PHASE_BIT || (CHIP_INDEX != 5'd0) || SIGNAL_GEN_OVER))
                stray++;
            if (RF_GATE) begin
                if (rf_cnt < 64) trace[rf_cnt] = PHASE_BIT;
                isum += int'(CHIP_INDEX);
                rf_cnt++;
            end
            if (SIGNAL_GEN_OVER && !over_q) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_over actual 1 required 0 at cycle %0d", cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk({e.name, "_over_latency"}, 64'(cyc + 1 - t_gen), 64'(e.lat));
                    chk({e.name, "_rf_cycles"},    64'(rf_cnt),          64'(e.rf));
                    chk({e.name, "_phase_trace"},  trace,                e.trace);
                    chk({e.name, "_index_sum"},    64'(isum),            64'(e.isum));
                end
            end
            if (!SIGNAL_GEN_OVER && over_q && RESET_N)
                chk("over_fall_edge", 64'(cyc), 64'(t_fall));
            over_q = SIGNAL_GEN_OVER;
        end
    end

    // Issue one pulse (called at a negedge) and push its expected report.
    task automatic pulse(input string nm, input logic [31:0] c, input logic [15:0] n,
                         input logic [15:0] d, input logic [15:0] p, input logic en,
                         input int lat, input int rf, input logic [63:0] tr,
                         input int isv, input int gap, input bit scramble);
        exp_t e;
        bit   ok;
        e.name = nm; e.lat = lat; e.rf = rf; e.trace = tr; e.isum = isv;
        exp_q.push_back(e);
        CODE = c; CODE_LEN = n; CODE_DURATION = d; PULSE_LEN = p;
        RF_OUTPUT_EN = en; GEN = 1'b1;
        if (scramble) begin
            @(negedge CLOCK_10M);
            CODE = ~c; CODE_LEN = 16'd1; CODE_DURATION = 16'd7; PULSE_LEN = 16'd100;
        end
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLOCK_10M);
            if (SIGNAL_GEN_OVER) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_over_timeout actual 0 required 1", nm);
        end else begin
            repeat (2) @(negedge CLOCK_10M);
            chk({nm, "_over_hold"}, 64'(SIGNAL_GEN_OVER), 64'd1);
        end
        GEN = 1'b0;
        repeat (gap) @(negedge CLOCK_10M);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_N = 1'b0; GEN = 1'b0; CODE = '0; CODE_LEN = '0;
        CODE_DURATION = '0; PULSE_LEN = '0; RF_OUTPUT_EN = 1'b0;
        #3;
        chk("reset_outputs", 64'({RF_GATE, PHASE_BIT, CHIP_INDEX, GEN_BUSY, SIGNAL_GEN_OVER}), 64'd0);
        repeat (2) @(negedge CLOCK_10M);
        RESET_N = 1'b1;
        @(negedge CLOCK_10M);
        chk("idle_busy", 64'(GEN_BUSY), 64'd0);

        // Basic pulse, parameters changed mid-pulse must be ignored.
        pulse("basic",   32'h5,         16'd3,  16'd4, 16'd20, 1'b1, 21, 12, 64'hF0F,       12,  3, 1'b1);
        pulse("clamp32", 32'hA5A5_3C3C, 16'd40, 16'd1, 16'd0,  1'b1, 33, 32, 64'hA5A5_3C3C, 496, 3, 1'b0);
        pulse("n0_p5",   32'hFFFF_FFFF, 16'd0,  16'd0, 16'd5,  1'b1, 6,  0,  64'h0,         0,   3, 1'b0);
        pulse("n0_p0",   32'hFFFF_FFFF, 16'd0,  16'd0, 16'd0,  1'b1, 1,  0,  64'h0,         0,   3, 1'b0);
        pulse("tx_gt_p", 32'h2,         16'd2,  16'd3, 16'd4,  1'b1, 7,  6,  64'h38,        3,   3, 1'b0);
        pulse("tx_eq_p", 32'h1,         16'd1,  16'd5, 16'd5,  1'b1, 6,  5,  64'h1F,        0,   3, 1'b0);
        pulse("d0",      32'h6,         16'd3,  16'd0, 16'd0,  1'b1, 4,  3,  64'h6,         3,   3, 1'b0);
        pulse("rf_off",  32'h3,         16'd2,  16'd2, 16'd0,  1'b0, 5,  0,  64'h0,         0,   3, 1'b0);

        // Abort: GEN dropped during elapsed cycle 3 of a 4x2 pulse.
        CODE = 32'hF; CODE_LEN = 16'd4; CODE_DURATION = 16'd2; PULSE_LEN = 16'd0;
        RF_OUTPUT_EN = 1'b1; GEN = 1'b1;
        @(posedge CLOCK_10M);
        repeat (3) @(posedge CLOCK_10M);
        #1 chk("abort_rf_before", 64'(RF_GATE), 64'd1);
        @(negedge CLOCK_10M);
        GEN = 1'b0;
        @(posedge CLOCK_10M);
        #1 chk("abort_outputs", 64'({RF_GATE, PHASE_BIT, GEN_BUSY, SIGNAL_GEN_OVER}), 64'd0);
        repeat (4) @(negedge CLOCK_10M);
        chk("abort_no_over", 64'({SIGNAL_GEN_OVER, GEN_BUSY}), 64'd0);

        // Asynchronous reset in the middle of transmission.
        CODE = 32'hAA; CODE_LEN = 16'd8; CODE_DURATION = 16'd4; PULSE_LEN = 16'd0;
        GEN = 1'b1;
        repeat (5) @(negedge CLOCK_10M);
        chk("rst_mid_rf_before", 64'(RF_GATE), 64'd1);
        #2 RESET_N = 1'b0;
        #1 chk("rst_mid_outputs", 64'({RF_GATE, PHASE_BIT, CHIP_INDEX, GEN_BUSY, SIGNAL_GEN_OVER}), 64'd0);
        GEN = 1'b0;
        @(negedge CLOCK_10M);
        RESET_N = 1'b1;
        @(negedge CLOCK_10M);
        pulse("after_rst", 32'h3, 16'd2, 16'd3, 16'd8, 1'b1, 9, 6, 64'h3F, 3, 3, 1'b0);

        // Back-to-back pulses with GEN low for two cycles in between.
        pulse("b2b_a", 32'h1, 16'd2, 16'd1, 16'd3, 1'b1, 4, 2, 64'h1, 1, 2, 1'b0);
        pulse("b2b_b", 32'h1, 16'd1, 16'd2, 16'd0, 1'b1, 3, 2, 64'h3, 0, 4, 1'b0);

        repeat (3) @(negedge CLOCK_10M);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        chk("idle_outputs_clean", 64'(stray), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
